// File: rtl/i2c_pkg.sv
// i2c_pkg: shared state encoding and protocol constants for the I2C EEPROM target
// and the master's read path.
package i2c_pkg;
    typedef enum logic [3:0] {
        IDLE, DEV, DEV_ACK, WADDR, WADDR_ACK, WDATA, WDATA_ACK, RDATA, RD_ACK
    } i2c_tgt_state_t;
    localparam logic [7:0] I2C_CTRL_WRITE = 8'hA0;
    localparam logic [7:0] I2C_CTRL_READ  = 8'hA1;
    localparam logic       I2C_ACK        = 1'b0;
    localparam logic       I2C_NACK       = 1'b1;
    localparam logic [6:0] I2C_DEV_ADDR   = 7'h50;
endpackage

// File: rtl/i2c_line_sync.sv
// i2c_line_sync: synchronizes SCL/SDA and derives one-CLK edge, START and STOP pulses.
// Flops reset to 1 so an idle (pulled-up) bus produces no spurious edges at release.
module i2c_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic CLK,
    input  logic RESET,
    input  logic SCL_IN,
    input  logic SDA_IN,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);
    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
    logic scl_dly_q, scl_dly_d, sda_dly_q, sda_dly_d, scl;

    always_comb begin
        scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], SCL_IN};
        sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], SDA_IN};
        scl_dly_d  = scl_sync_q[SYNC_STAGES-1];
        sda_dly_d  = sda_sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_dly_q  <= 1'b1;
            sda_dly_q  <= 1'b1;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_dly_q  <= scl_dly_d;
            sda_dly_q  <= sda_dly_d;
        end
    end

    assign scl       = scl_sync_q[SYNC_STAGES-1];
    assign sda       = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise  = scl & ~scl_dly_q;
    assign scl_fall  = ~scl & scl_dly_q;
    assign start_det = scl & scl_dly_q & sda_dly_q & ~sda;
    assign stop_det  = scl & scl_dly_q & ~sda_dly_q & sda;
endmodule

// File: rtl/i2c_eeprom_responder.sv
// i2c_eeprom_responder: I2C target emulating a small serial EEPROM with byte write
// and random/sequential read from an internal register file.
module i2c_eeprom_responder
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR    = I2C_DEV_ADDR,
    parameter int         ADDR_BITS   = 4,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 SCL_IN,
    input  logic                 SDA_IN,
    output logic                 SDA_OE,
    output logic                 BUSY,
    output logic                 WR_STB,
    output logic [ADDR_BITS-1:0] WR_ADDR,
    output logic [7:0]           WR_DATA,
    input  logic [ADDR_BITS-1:0] DBG_ADDR,
    output logic [7:0]           DBG_DATA
);
    localparam int DEPTH = 2 ** ADDR_BITS;

    logic sda, scl_rise, scl_fall, start_det, stop_det;

    i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .CLK(CLK), .RESET(RESET), .SCL_IN(SCL_IN), .SDA_IN(SDA_IN),
        .sda(sda), .scl_rise(scl_rise), .scl_fall(scl_fall),
        .start_det(start_det), .stop_det(stop_det)
    );

    i2c_tgt_state_t       state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [7:0]           shift_q, shift_d, tx_q, tx_d;
    logic [ADDR_BITS-1:0] ptr_q, ptr_d, wr_addr_q, wr_addr_d;
    logic [7:0]           wr_data_q, wr_data_d;
    logic                 oe_q, oe_d, busy_q, busy_d, wr_stb_q, wr_stb_d;
    logic [7:0]           mem_q [DEPTH];
    logic [7:0]           mem_d [DEPTH];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        ptr_d     = ptr_q;
        oe_d      = oe_q;
        busy_d    = busy_q;
        wr_stb_d  = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        mem_d     = mem_q;
        if (start_det) begin
            state_d = DEV;
            cnt_d   = 4'd0;
            oe_d    = 1'b0;
        end else if (stop_det) begin
            state_d = IDLE;
            oe_d    = 1'b0;
            busy_d  = 1'b0;
        end else if (scl_rise) begin
            case (state_q)
                DEV, WADDR, WDATA: begin
                    shift_d = {shift_q[6:0], sda};
                    cnt_d   = cnt_q + 4'd1;
                    if (cnt_q == 4'd7) begin
                        cnt_d = 4'd0;
                        if (state_q == DEV) begin
                            busy_d  = shift_d[7:1] == DEV_ADDR;
                            state_d = busy_d ? DEV_ACK : IDLE;
                        end else if (state_q == WADDR) begin
                            ptr_d   = shift_d[7 -: ADDR_BITS];
                            state_d = WADDR_ACK;
                        end else begin
                            mem_d[ptr_q] = shift_d;
                            wr_stb_d     = 1'b1;
                            wr_addr_d    = ptr_q;
                            wr_data_d    = shift_d;
                            state_d      = WDATA_ACK;
                        end
                    end
                end
                RDATA: cnt_d = cnt_q + 4'd1;
                RD_ACK: begin
                    if (sda == I2C_ACK) begin
                        ptr_d   = ptr_q + 1'b1;
                        tx_d    = mem_q[ptr_d];
                        cnt_d   = 4'd0;
                        state_d = RDATA;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: ;
            endcase
        end else if (scl_fall) begin
            case (state_q)
                // first fall starts driving the ACK, second fall ends the 9th clock
                DEV_ACK, WADDR_ACK, WDATA_ACK: begin
                    oe_d = ~oe_q;
                    if (oe_q) begin
                        cnt_d   = 4'd0;
                        state_d = state_q != DEV_ACK ? WDATA : (shift_q[0] ? RDATA : WADDR);
                        if (state_q == WDATA_ACK) ptr_d = ptr_q + 1'b1;
                        if (state_q == DEV_ACK && shift_q[0]) begin
                            tx_d = mem_q[ptr_q];
                            oe_d = ~mem_q[ptr_q][7];
                        end
                    end
                end
                RDATA: begin
                    oe_d    = cnt_q == 4'd8 ? 1'b0 : ~tx_q[3'd7 - cnt_q[2:0]];
                    state_d = cnt_q == 4'd8 ? RD_ACK : RDATA;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            shift_q   <= 8'h00;
            tx_q      <= 8'h00;
            ptr_q     <= '0;
            oe_q      <= 1'b0;
            busy_q    <= 1'b0;
            wr_stb_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= 8'h00;
            mem_q     <= '{default: 8'h00};
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            ptr_q     <= ptr_d;
            oe_q      <= oe_d;
            busy_q    <= busy_d;
            wr_stb_q  <= wr_stb_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            mem_q     <= mem_d;
        end
    end

    assign SDA_OE   = oe_q;
    assign BUSY     = busy_q;
    assign WR_STB   = wr_stb_q;
    assign WR_ADDR  = wr_addr_q;
    assign WR_DATA  = wr_data_q;
    assign DBG_DATA = mem_q[DBG_ADDR];
endmodule

// File: tb/tb_i2c_eeprom_responder.sv
// tb_i2c_eeprom_responder: bit-banged I2C master against the EEPROM target, with
// scoreboard queues for committed writes and returned read bytes.
module tb_i2c_eeprom_responder;
    import i2c_pkg::*;

    localparam int T = 100;

    logic       CLK = 1'b0, RESET = 1'b1, scl = 1'b1, sda_m = 1'b1;
    logic       SDA_OE, BUSY, WR_STB;
    logic [3:0] WR_ADDR, DBG_ADDR = 4'd0;
    logic [7:0] WR_DATA, DBG_DATA;
    wire        sda_bus = sda_m & ~SDA_OE;

    int checks = 0, errors = 0;
    logic [11:0] wq[$];
    logic [7:0]  rq[$];

    i2c_eeprom_responder dut (
        .CLK(CLK), .RESET(RESET), .SCL_IN(scl), .SDA_IN(sda_bus),
        .SDA_OE(SDA_OE), .BUSY(BUSY), .WR_STB(WR_STB), .WR_ADDR(WR_ADDR),
        .WR_DATA(WR_DATA), .DBG_ADDR(DBG_ADDR), .DBG_DATA(DBG_DATA)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic bit_out(input logic b);
        sda_m = b;
        #T scl = 1'b1;
        #(2*T) scl = 1'b0;
        #T;
    endtask

    task automatic bit_in(output logic b);
        sda_m = 1'b1;
        #T scl = 1'b1;
        #T b = sda_bus;
        #T scl = 1'b0;
        #T;
    endtask

    task automatic start_c();
        sda_m = 1'b1;
        #T scl = 1'b1;
        #T sda_m = 1'b0;
        #T scl = 1'b0;
        #T;
    endtask

    task automatic stop_c();
        sda_m = 1'b0;
        #T scl = 1'b1;
        #T sda_m = 1'b1;
        #T;
    endtask

    task automatic send_byte(input logic [7:0] v, output logic ack);
        for (int i = 7; i >= 0; i--) bit_out(v[i]);
        bit_in(ack);
    endtask

    task automatic recv_byte(input logic ack, output logic [7:0] v);
        for (int i = 7; i >= 0; i--) bit_in(v[i]);
        bit_out(ack);
    endtask

    task automatic read_check(input string tag, input logic ack);
        logic [7:0] v, e;
        recv_byte(ack, v);
        if (rq.size() == 0) check({tag, "_noexp"}, 32'(v), 32'hFFFF_FFFF);
        else begin
            e = rq.pop_front();
            check(tag, 32'(v), 32'(e));
        end
    endtask

    always @(negedge CLK) begin
        logic [11:0] e;
        if (WR_STB) begin
            if (wq.size() == 0) check("wr_unexpected", 32'(WR_STB), 32'd0);
            else begin
                e = wq.pop_front();
                check("wr_commit", 32'({WR_ADDR, WR_DATA}), 32'(e));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic ack;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_oe", 32'(SDA_OE), 32'd0);
        check("rst_busy", 32'(BUSY), 32'd0);
        check("rst_stb", 32'(WR_STB), 32'd0);
        check("rst_waddr_wdata", 32'({WR_ADDR, WR_DATA}), 32'd0);
        check("rst_mem0", 32'(DBG_DATA), 32'd0);
        RESET = 1'b0;
        repeat (5) @(posedge CLK);

        // byte write 0x3C to address 5
        start_c();
        send_byte(I2C_CTRL_WRITE, ack);
        check("wr_dev_ack", 32'(ack), 32'(I2C_ACK));
        check("wr_busy", 32'(BUSY), 32'd1);
        send_byte(8'h50, ack);
        check("wr_addr_ack", 32'(ack), 32'(I2C_ACK));
        wq.push_back({4'd5, 8'h3C});
        send_byte(8'h3C, ack);
        check("wr_data_ack", 32'(ack), 32'(I2C_ACK));
        stop_c();
        check("wr_busy_stop", 32'(BUSY), 32'd0);
        check("wr_q_empty", 32'(wq.size()), 32'd0);
        check("wr_last", 32'({WR_ADDR, WR_DATA}), 32'h53C);
        DBG_ADDR = 4'd5;
        #1 check("wr_dbg5", 32'(DBG_DATA), 32'h3C);

        // random read of address 5 via repeated START, master NACK
        start_c();
        send_byte(I2C_CTRL_WRITE, ack);
        send_byte(8'h50, ack);
        start_c();
        send_byte(I2C_CTRL_READ, ack);
        check("rd_dev_ack", 32'(ack), 32'(I2C_ACK));
        rq.push_back(8'h3C);
        read_check("rd_byte5", I2C_NACK);
        check("rd_busy_nack", 32'(BUSY), 32'd1);
        check("rd_oe_nack", 32'(SDA_OE), 32'd0);
        stop_c();
        check("rd_busy_stop", 32'(BUSY), 32'd0);

        // address mismatch: control byte 0xA4
        start_c();
        send_byte(8'hA4, ack);
        check("mm_nack", 32'(ack), 32'(I2C_NACK));
        check("mm_busy", 32'(BUSY), 32'd0);
        check("mm_oe", 32'(SDA_OE), 32'd0);
        stop_c();
        #1 check("mm_mem", 32'(DBG_DATA), 32'h3C);

        // sequential write across the wrap: addr 15 = 0x11, addr 0 = 0x22
        start_c();
        send_byte(I2C_CTRL_WRITE, ack);
        send_byte(8'hF0, ack);
        wq.push_back({4'd15, 8'h11});
        send_byte(8'h11, ack);
        wq.push_back({4'd0, 8'h22});
        send_byte(8'h22, ack);
        check("seq_ack", 32'(ack), 32'(I2C_ACK));
        stop_c();
        check("seq_q_empty", 32'(wq.size()), 32'd0);

        // sequential read from 15 wraps to 0
        start_c();
        send_byte(I2C_CTRL_WRITE, ack);
        send_byte(8'hF0, ack);
        start_c();
        send_byte(I2C_CTRL_READ, ack);
        rq.push_back(8'h11);
        rq.push_back(8'h22);
        read_check("wrap_rd15", I2C_ACK);
        read_check("wrap_rd0", I2C_NACK);
        stop_c();

        // partial data byte aborted by STOP
        start_c();
        send_byte(I2C_CTRL_WRITE, ack);
        send_byte(8'h20, ack);
        for (int i = 0; i < 4; i++) bit_out(1'b1);
        stop_c();
        DBG_ADDR = 4'd2;
        #1 check("part_mem2", 32'(DBG_DATA), 32'd0);
        check("part_state", 32'(dut.state_q), 32'(IDLE));
        check("part_oe", 32'(SDA_OE), 32'd0);
        check("part_busy", 32'(BUSY), 32'd0);
        check("part_q_empty", 32'(wq.size()), 32'd0);

        // reset while the target drives bit 7 (0) of 0x3C
        start_c();
        send_byte(I2C_CTRL_WRITE, ack);
        send_byte(8'h50, ack);
        start_c();
        send_byte(I2C_CTRL_READ, ack);
        check("arst_driving", 32'(SDA_OE), 32'd1);
        @(posedge CLK);
        #3 RESET = 1'b1;
        #1 check("arst_oe", 32'(SDA_OE), 32'd0);
        check("arst_busy", 32'(BUSY), 32'd0);
        for (int a = 0; a < 16; a++) begin
            DBG_ADDR = 4'(a);
            #1 check($sformatf("arst_mem%0d", a), 32'(DBG_DATA), 32'd0);
        end
        scl = 1'b1;
        sda_m = 1'b1;
        repeat (4) @(posedge CLK);
        RESET = 1'b0;
        repeat (10) @(posedge CLK);
        #1 check("arst_idle", 32'(dut.state_q), 32'(IDLE));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
